decoder_ld_r_n_seq: RTL and testbench

Sequenced, parametrised decoder for the LD r,n instruction class. It latches the register-select field from ITABLE, holds the operand fetch until the immediate byte arrives, then writes it to a one-hot register port (or to memory for the (HL) code). It pulses the end-of-instruction controls (CM1 set, ITABLE reset, XPT reset). It sits in the instruction decoder between the ITABLE latch and the register file / memory write path.

---
 rtl/decoder_ld_r_n_seq.sv | 186 ++++++++++++++++++
 tb/tb_decoder_ld_r_n_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_ld_r_n_seq.sv
// ---------------------------------------------------------------------------
// decoder_ld_r_n_seq
//
// Sequenced decoder for the LD r,n instruction class. An accepted opcode
// latches the register-select field from ITABLE, holds operand fetch until
// the immediate byte arrives, then writes it to a one-hot register port
// (or, when LD_MEM_EN is defined, to memory for the (HL) code), and finally
// pulses the end-of-instruction controls for one cycle.
//
// Optional feature macro: LD_MEM_EN
//   defined   : code 2**SEL_W-2 goes through WRITE_MEM with a mem_ready handshake
//   undefined : code 2**SEL_W-2 writes A; Mem_Write / Mem_Data tied 0
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   enable            opcode matched (sampled in IDLE only)
//   ITABLE            current instruction byte (select field source)
//   flush             synchronous abort to IDLE
//   operand_valid     immediate byte present on operand
//   operand           immediate byte
//   mem_ready         memory accepted write (LD_MEM_EN only)
//   PR_Write/PR_Data  one-hot register write strobe and write data
//   PR_InvertIn       high with writes to A, B, D, H
//   Pa_Ophd           operand-fetch hold (FETCH)
//   P2_Set_CM1, P2_Reset_ITABLE, PR_Reset_XPT  end-of-instruction pulses
//   Mem_Write/Mem_Data  memory write request and data
//   timeout           one-cycle pulse after an operand-fetch abort
//   busy              state != IDLE
// ---------------------------------------------------------------------------
module decoder_ld_r_n_seq #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned SEL_LSB  = 0,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  enable,
    input  logic [7:0]            ITABLE,
    input  logic                  flush,
    input  logic                  operand_valid,
    input  logic [DATA_W-1:0]     operand,
    input  logic                  mem_ready,
    output logic [2**SEL_W-1:0]   PR_Write,
    output logic [DATA_W-1:0]     PR_Data,
    output logic                  PR_InvertIn,
    output logic                  Pa_Ophd,
    output logic                  P2_Set_CM1,
    output logic                  P2_Reset_ITABLE,
    output logic                  PR_Reset_XPT,
    output logic                  Mem_Write,
    output logic [DATA_W-1:0]     Mem_Data,
    output logic                  timeout,
    output logic                  busy
);

    localparam int unsigned      S         = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] SEL_A     = SEL_W'(S - 1);
    localparam logic [SEL_W-1:0] SEL_HL    = SEL_W'(S - 2);
    localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_WRITE_REG = 3'd2;
`ifdef LD_MEM_EN
    localparam logic [2:0] ST_WRITE_MEM = 3'd3;
`endif
    localparam logic [2:0] ST_DONE      = 3'd4;

    logic [2:0]        state_q,   state_d;
    logic [SEL_W-1:0]  sel_q,     sel_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [7:0]        cnt_q,     cnt_d;
    logic              timeout_q, timeout_d;
    logic [SEL_W-1:0]  sel_eff;

    // Only the select field of ITABLE is decoded here.
    logic unused_itable;
    assign unused_itable = ^ITABLE;

`ifndef LD_MEM_EN
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    // Next-state logic; flush overrides everything except RESET.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        operand_d = operand_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        sel_d   = ITABLE[SEL_LSB +: SEL_W];
                        cnt_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (operand_valid) begin
                        operand_d = operand;
`ifdef LD_MEM_EN
                        state_d = (sel_q == SEL_HL) ? ST_WRITE_MEM : ST_WRITE_REG;
`else
                        state_d = ST_WRITE_REG;
`endif
                    end else if (cnt_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_WRITE_REG: state_d = ST_DONE;
`ifdef LD_MEM_EN
                ST_WRITE_MEM: begin
                    if (mem_ready) begin
                        state_d = ST_DONE;
                    end
                end
`endif
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            operand_q <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            operand_q <= operand_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Without the memory path the (HL) code falls back to the legacy A decode.
    always_comb begin
`ifdef LD_MEM_EN
        sel_eff = sel_q;
`else
        sel_eff = (sel_q == SEL_HL) ? SEL_A : sel_q;
`endif
    end

    // All outputs decode registered state only.
    always_comb begin
        PR_Write    = '0;
        PR_Data     = '0;
        PR_InvertIn = 1'b0;
        if (state_q == ST_WRITE_REG) begin
            PR_Write[sel_eff] = 1'b1;
            PR_Data           = operand_q;
            // A, and the high half (even code) of each register pair.
            PR_InvertIn       = (sel_eff == SEL_A) || (!sel_eff[0] && (sel_eff < SEL_HL));
        end
    end

    assign Pa_Ophd         = (state_q == ST_FETCH);
    assign P2_Set_CM1      = (state_q == ST_DONE);
    assign P2_Reset_ITABLE = (state_q == ST_DONE);
    assign PR_Reset_XPT    = (state_q == ST_DONE);
    assign timeout         = timeout_q;
    assign busy            = (state_q != ST_IDLE);

`ifdef LD_MEM_EN
    assign Mem_Write = (state_q == ST_WRITE_MEM);
    assign Mem_Data  = (state_q == ST_WRITE_MEM) ? operand_q : '0;
`else
    assign Mem_Write = 1'b0;
    assign Mem_Data  = '0;
`endif

endmodule

// File: tb/tb_decoder_ld_r_n_seq.sv
// ---------------------------------------------------------------------------
// tb_decoder_ld_r_n_seq
//
// Self-checking bench for decoder_ld_r_n_seq (WAIT_MAX overridden to 4).
// A frame-scheduling reference model predicts every output each cycle;
// directed vectors and sequences add constant expectations on top.
// Honours LD_MEM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_decoder_ld_r_n_seq;

    localparam int DW = 8;
    localparam int SW = 3;
    localparam int S  = 8;
    localparam int WM = 4;
`ifdef LD_MEM_EN
    localparam bit MEM = 1'b1;
`else
    localparam bit MEM = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET, enable, flush, operand_valid, mem_ready;
    logic [7:0]    ITABLE;
    logic [DW-1:0] operand;
    logic [S-1:0]  PR_Write;
    logic [DW-1:0] PR_Data, Mem_Data;
    logic          PR_InvertIn, Pa_Ophd, P2_Set_CM1, P2_Reset_ITABLE, PR_Reset_XPT;
    logic          Mem_Write, timeout, busy;

    always #5 CLK = ~CLK;

    decoder_ld_r_n_seq #(
        .DATA_W  (DW),
        .SEL_W   (SW),
        .SEL_LSB (0),
        .WAIT_MAX(WM)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .enable         (enable),
        .ITABLE         (ITABLE),
        .flush          (flush),
        .operand_valid  (operand_valid),
        .operand        (operand),
        .mem_ready      (mem_ready),
        .PR_Write       (PR_Write),
        .PR_Data        (PR_Data),
        .PR_InvertIn    (PR_InvertIn),
        .Pa_Ophd        (Pa_Ophd),
        .P2_Set_CM1     (P2_Set_CM1),
        .P2_Reset_ITABLE(P2_Reset_ITABLE),
        .PR_Reset_XPT   (PR_Reset_XPT),
        .Mem_Write      (Mem_Write),
        .Mem_Data       (Mem_Data),
        .timeout        (timeout),
        .busy           (busy)
    );

    typedef struct packed {
        logic [7:0] wr;
        logic [7:0] data;
        logic       inv;
        logic       ophd;
        logic [2:0] done;
        logic       memw;
        logic [7:0] memd;
        logic       tmo;
        logic       bsy;
    } frame_t;

    typedef struct {
        logic [7:0] itable;
        logic [7:0] op;
        int         delay;
        logic [7:0] wr;
        logic       inv;
        logic       mem;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    frame_t cur;
    bit     fetching;
    int     waited;
    int     msel;
    frame_t sched[$];
    vec_t   vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame builders straight from the behavioural rules.
    function automatic frame_t fetch_f();
        frame_t f = '0;
        f.ophd = 1'b1;
        f.bsy  = 1'b1;
        return f;
    endfunction

    function automatic frame_t done_f();
        frame_t f = '0;
        f.done = 3'b111;
        f.bsy  = 1'b1;
        return f;
    endfunction

    function automatic frame_t write_f(input int code, input logic [7:0] op);
        frame_t f = '0;
        int eff = (code == S - 2 && !MEM) ? S - 1 : code;
        f.wr   = 8'(1) << eff;
        f.data = op;
        f.inv  = (eff == S - 1) || (eff < S - 2 && eff % 2 == 0);
        f.bsy  = 1'b1;
        return f;
    endfunction

    function automatic frame_t mem_f(input logic [7:0] op);
        frame_t f = '0;
        f.memw = 1'b1;
        f.memd = op;
        f.bsy  = 1'b1;
        return f;
    endfunction

    function automatic frame_t dut_frame();
        frame_t f;
        f.wr   = PR_Write;
        f.data = PR_Data;
        f.inv  = PR_InvertIn;
        f.ophd = Pa_Ophd;
        f.done = {P2_Set_CM1, P2_Reset_ITABLE, PR_Reset_XPT};
        f.memw = Mem_Write;
        f.memd = Mem_Data;
        f.tmo  = timeout;
        f.bsy  = busy;
        return f;
    endfunction

    // Data fields only carry meaning while their strobe is expected.
    function automatic frame_t mask(input frame_t f, input frame_t e);
        frame_t m = f;
        if (e.wr == 0) m.data = '0;
        if (!e.memw) m.memd = '0;
        return m;
    endfunction

    // Predict the next cycle's outputs from the current inputs.
    task automatic model_next(output frame_t n);
        n = '0;
        if (RESET || flush) begin
            fetching = 0;
            sched.delete();
        end else if (fetching) begin
            if (operand_valid) begin
                fetching = 0;
                if (MEM && msel == S - 2) sched.push_back(mem_f(operand));
                else sched.push_back(write_f(msel, operand));
                sched.push_back(done_f());
                n = sched.pop_front();
            end else if (waited == WM - 1) begin
                fetching = 0;
                n.tmo    = 1'b1;
            end else begin
                waited++;
                n = fetch_f();
            end
        end else if (cur.memw && !mem_ready) begin
            n = cur;
        end else if (sched.size() > 0) begin
            n = sched.pop_front();
        end else if (!cur.bsy && enable) begin
            fetching = 1;
            waited   = 0;
            msel     = int'(ITABLE) % S;
            n        = fetch_f();
        end
    endtask

    task automatic step();
        frame_t nxt;
        model_next(nxt);
        @(posedge CLK);
        #1;
        cur = nxt;
        chk("model_frame", mask(dut_frame(), cur), mask(cur, cur));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{8'h02, 8'h5A, 0, 8'h04, 1'b1, 1'b0};
        vecs[1] = '{8'h05, 8'h3C, 3, 8'h20, 1'b0, 1'b0};
        vecs[2] = '{8'h06, 8'hA5, 0, (MEM ? 8'h00 : 8'h80), !MEM, MEM};
        vecs[3] = '{8'h07, 8'h11, 1, 8'h80, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'hFF, 2, 8'h01, 1'b1, 1'b0};
        vecs[5] = '{8'h01, 8'h00, 0, 8'h02, 1'b0, 1'b0};
        vecs[6] = '{8'hF3, 8'h81, 1, 8'h08, 1'b0, 1'b0};
        vecs[7] = '{8'h0C, 8'h42, 0, 8'h10, 1'b1, 1'b0};

        cur           = '0;
        fetching      = 0;
        waited        = 0;
        msel          = 0;
        RESET         = 1'b1;
        enable        = 1'b0;
        flush         = 1'b0;
        operand_valid = 1'b0;
        operand       = '0;
        mem_ready     = 1'b1;
        ITABLE        = '0;
        step();
        step();
        chk("reset_outputs", dut_frame(), 32'h0);
        RESET = 1'b0;
        step();

        // Table-driven register / memory writes.
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            mem_ready = v.mem ? 1'b0 : 1'b1;
            enable = 1'b1;
            ITABLE = v.itable;
            step();
            enable = 1'b0;
            ITABLE = 8'($urandom);
            chk("ophd_first", Pa_Ophd, 1);
            for (int d = 0; d < v.delay; d++) begin
                step();
                chk("ophd_wait", Pa_Ophd, 1);
            end
            operand_valid = 1'b1;
            operand       = v.op;
            step();
            operand_valid = 1'b0;
            operand       = 8'($urandom);
            chk("wr_strobe", PR_Write, v.wr);
            chk("wr_invert", PR_InvertIn, v.inv);
            chk("mem_write", Mem_Write, v.mem);
            if (v.wr != 0) chk("wr_data", PR_Data, v.op);
            if (v.mem) begin
                chk("mem_data", Mem_Data, v.op);
                repeat (2) begin
                    step();
                    chk("mem_hold", Mem_Write, 1);
                    chk("mem_data_hold", Mem_Data, v.op);
                    chk("mem_no_reg", PR_Write, 0);
                end
                mem_ready = 1'b1;
            end
            step();
            chk("done_pulses", {P2_Set_CM1, P2_Reset_ITABLE, PR_Reset_XPT}, 3'b111);
            step();
            chk("idle_after", {busy, P2_Set_CM1, P2_Reset_ITABLE, PR_Reset_XPT}, 0);
        end

        // Operand never arrives: WAIT_MAX fetch cycles, then timeout.
        enable = 1'b1;
        ITABLE = 8'h03;
        step();
        enable = 1'b0;
        chk("to_ophd", Pa_Ophd, 1);
        for (int c = 1; c < WM; c++) begin
            step();
            chk("to_ophd", Pa_Ophd, 1);
        end
        step();
        chk("to_pulse", timeout, 1);
        chk("to_state", {Pa_Ophd, busy, PR_Write}, 0);
        chk("to_no_done", {P2_Set_CM1, P2_Reset_ITABLE, PR_Reset_XPT}, 0);
        step();
        chk("to_single", {timeout, busy}, 0);

        // Flush in FETCH beats a simultaneous operand.
        enable = 1'b1;
        ITABLE = 8'h04;
        step();
        enable        = 1'b0;
        operand_valid = 1'b1;
        operand       = 8'h77;
        flush         = 1'b1;
        step();
        flush         = 1'b0;
        operand_valid = 1'b0;
        chk("flush_idle", {busy, PR_Write, P2_Set_CM1}, 0);
        step();
        chk("flush_no_write", {busy, PR_Write}, 0);

        // Flush together with enable in IDLE: enable ignored.
        enable = 1'b1;
        flush  = 1'b1;
        step();
        enable = 1'b0;
        flush  = 1'b0;
        chk("flush_enable", busy, 0);

        // RESET during the write state clears everything next cycle.
        mem_ready = 1'b0;
        enable    = 1'b1;
        ITABLE    = 8'h06;
        step();
        enable        = 1'b0;
        operand_valid = 1'b1;
        operand       = 8'hC3;
        step();
        operand_valid = 1'b0;
        chk("pre_reset_write", Mem_Write | (PR_Write != 0), 1);
        RESET = 1'b1;
        step();
        RESET     = 1'b0;
        mem_ready = 1'b1;
        chk("reset_mid_write", dut_frame(), 32'h0);

        // Back-to-back with enable held high and operand always valid.
        enable        = 1'b1;
        operand_valid = 1'b1;
        operand       = 8'h12;
        ITABLE        = 8'h07;
        step();
        ITABLE = 8'h00;
        step();
        chk("b2b_first", PR_Write, 8'h80);
        step();
        chk("b2b_done", P2_Set_CM1, 1);
        step();
        chk("b2b_gap", busy, 0);
        step();
        step();
        chk("b2b_second", PR_Write, 8'h01);
        enable        = 1'b0;
        operand_valid = 1'b0;
        step();
        step();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            RESET         = ($urandom % 150) == 0;
            flush         = ($urandom % 25) == 0;
            enable        = ($urandom % 2) == 0;
            operand_valid = ($urandom % 3) == 0;
            mem_ready     = ($urandom % 2) == 0;
            operand       = 8'($urandom);
            ITABLE        = 8'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
